// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline datapath and its issue/collect driver.
// Holds the driver state encoding, default widths and a small popcount helper.
package pipeline_pkg;

  localparam int DEF_W   = 32;
  localparam int DEF_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of set bits; the in-flight tracker is zero-extended into this.
  function automatic logic [31:0] popcnt32(input logic [31:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipeline_driver_if.sv
// Controller, pipeline-operand and result-stream signals of pipeline_driver.
// The master modport is the driver's view; slave is the surrounding system.
interface pipeline_driver_if
  import pipeline_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start;
  logic [7:0]    count;
  logic [W-1:0]  base;
  logic [W-1:0]  a1;
  logic [W-1:0]  b1;
  logic [W-1:0]  a2;
  logic [W-1:0]  b2;
  logic [W-1:0]  c;
  logic          busy;
  logic          done;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_ready;
  logic [CW-1:0] res_cnt;

  modport master (
    input  start, count, base, c, res_ready,
    output a1, b1, a2, b2, busy, done, res_valid, res_data, res_cnt
  );

  modport slave (
    output start, count, base, c, res_ready,
    input  a1, b1, a2, b2, busy, done, res_valid, res_data, res_cnt
  );

endinterface

// File: rtl/pipeline_driver_result_fifo.sv
// Synchronous result FIFO; the parent's credit scheme guarantees it never
// overflows, so push is not gated on fullness.
module result_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DEF_W,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] cnt,
  output logic          valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_n_s;
  logic          valid_r;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(32'd1);
    end
  endfunction

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    cnt_n_s = cnt_r;
    case ({push, pop})
      2'b10:   cnt_n_s = cnt_r + CW'(32'd1);
      2'b01:   cnt_n_s = cnt_r - CW'(32'd1);
      default: cnt_n_s = cnt_r;
    endcase
  end

  // Storage, pointers and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      cnt_r   <= cnt_n_s;
      valid_r <= (cnt_n_s != '0);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign cnt   = cnt_r;
  assign valid = valid_r;

endmodule

// File: rtl/pipeline_driver.sv
// Issues operand bursts into the fixed-latency pipeline and collects the
// returning results into a credit-protected FIFO.
module pipeline_driver
  import pipeline_pkg::*;
#(
  parameter int LAT   = DEF_LAT,
  parameter int DEPTH = 4,
  parameter int W     = DEF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  pipeline_driver_if.master   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_r;
  state_e        state_n_s;
  logic [7:0]    cnt_r;
  logic [7:0]    idx_r;
  logic [W-1:0]  base_r;
  logic [W-1:0]  a1_r;
  logic [W-1:0]  b1_r;
  logic [W-1:0]  a2_r;
  logic [W-1:0]  b2_r;
  logic          busy_r;
  logic          done_r;
  logic [LAT-1:0] vld_r;
  logic [LAT-1:0] vld_n_s;
  logic [LAT:0]  shift_s;
  logic [LAT:0]  drain_shift_s;
  logic          drained_s;
  logic          issue_s;
  logic          credit_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   used_s;
  logic [W-1:0]  beat_base_s;
  logic [W-1:0]  fifo_data_s;
  logic [CW-1:0] fifo_cnt_s;
  logic          fifo_valid_s;

  assign push_s = vld_r[LAT-1];
  assign pop_s  = fifo_valid_s & bus.res_ready;

  // Credit: stored results plus in-flight beats, less this cycle's pop.
  always_comb begin
    used_s        = 32'(fifo_cnt_s) + popcnt32(32'(vld_r)) - 32'(pop_s);
    credit_s      = (used_s < 32'(DEPTH));
    drain_shift_s = {vld_r, 1'b0};
    drained_s     = (drain_shift_s[LAT-1:0] == '0);
  end

  // Next-state and issue decision.
  always_comb begin
    state_n_s = state_r;
    issue_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != 8'd0) begin
            state_n_s = ISSUE;
          end else begin
            state_n_s = DONE;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      ISSUE: begin
        if (credit_s) begin
          issue_s = 1'b1;
          if (idx_r == cnt_r - 8'd1) begin
            state_n_s = DRAIN;
          end else begin
            state_n_s = ISSUE;
          end
        end else begin
          state_n_s = ISSUE;
        end
      end
      DRAIN: begin
        // Leaves on the edge that pushes the final result.
        if (drained_s) begin
          state_n_s = DONE;
        end else begin
          state_n_s = DRAIN;
        end
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // Valid tracker shifts a 1 in on issue edges, 0 otherwise.
  always_comb begin
    shift_s     = {vld_r, issue_s};
    vld_n_s     = shift_s[LAT-1:0];
    beat_base_s = base_r + W'(idx_r);
  end

  // State, burst context, operand and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= 8'd0;
      base_r  <= '0;
      a1_r    <= '0;
      b1_r    <= '0;
      a2_r    <= '0;
      b2_r    <= '0;
      vld_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      vld_r   <= vld_n_s;
      busy_r  <= (state_n_s == ISSUE) || (state_n_s == DRAIN);
      done_r  <= (state_n_s == DONE);
      if ((state_r == IDLE) && bus.start && (bus.count != 8'd0)) begin
        cnt_r  <= bus.count;
        base_r <= bus.base;
        idx_r  <= 8'd0;
      end else if (issue_s) begin
        a1_r  <= beat_base_s;
        b1_r  <= beat_base_s + W'(32'd1);
        a2_r  <= beat_base_s + W'(32'd2);
        b2_r  <= beat_base_s + W'(32'd3);
        idx_r <= idx_r + 8'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (bus.c),
    .pop   (pop_s),
    .dout  (fifo_data_s),
    .cnt   (fifo_cnt_s),
    .valid (fifo_valid_s)
  );

  assign bus.a1        = a1_r;
  assign bus.b1        = b1_r;
  assign bus.a2        = a2_r;
  assign bus.b2        = b2_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.res_valid = fifo_valid_s;
  assign bus.res_data  = fifo_data_s;
  assign bus.res_cnt   = fifo_cnt_s;

endmodule
